// File: rtl/uart_cmd_parser_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_parser_pkg
//  Purpose  : Shared state encodings, error codes and defaults for the UART
//             command frame parser.
//  Revision : 1.0  initial release
// ============================================================================
package uart_cmd_parser_pkg;

  // Parser states; three unused encodings fall back to S_IDLE
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4
  } state_t;

  // Frame status codes reported on o_Err_Code
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CHK  = 2'b01;
  localparam logic [1:0] ERR_LEN  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  // Frame start marker
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_parser
//  Purpose  : Decodes SYNC/CMD/LEN/payload/CHK frames from UART byte strobes,
//             streams payload bytes and reports frame status. An inter-byte
//             timeout recovers stalled frames.
//  Revision : 1.0  initial release
// ============================================================================
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 43400
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic [7:0] o_Cmd,
  output logic [7:0] o_Len,
  output logic       o_Data_DV,
  output logic [7:0] o_Data_Byte,
  output logic [7:0] o_Data_Index,
  output logic       o_Frame_Done,
  output logic       o_Frame_Ok,
  output logic [1:0] o_Err_Code,
  output logic       o_Busy
);

  localparam logic [7:0]  C_MAX_LEN  = 8'(MAX_LEN);
  localparam logic [15:0] C_TMO_LAST = 16'(TIMEOUT_CLKS - 1);

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] timer_q, timer_d;
  logic        data_dv_q, data_dv_d;
  logic [7:0]  data_byte_q, data_byte_d;
  logic [7:0]  data_index_q, data_index_d;
  logic        done_q, done_d;
  logic        ok_q, ok_d;
  logic [1:0]  err_q, err_d;
  logic        busy_q, busy_d;
  logic        tmo_fire;

  // Expiry only counts in an active frame state and loses to a same-cycle strobe
  assign tmo_fire = !i_Rx_DV && (timer_q == C_TMO_LAST) &&
                    (state_q inside {S_CMD, S_LEN, S_PAYLOAD, S_CHK});

  // State register
  always_ff @(posedge i_Clock) begin
    if (i_Reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode on consumed bytes and timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) state_d = S_CMD;
      S_CMD:     if (i_Rx_DV) state_d = S_LEN;
      S_LEN:     if (i_Rx_DV) begin
                   if (i_Rx_Byte > C_MAX_LEN)  state_d = S_IDLE;
                   else if (i_Rx_Byte == 8'd0) state_d = S_CHK;
                   else                        state_d = S_PAYLOAD;
                 end
      S_PAYLOAD: if (i_Rx_DV && idx_q == len_q - 8'd1) state_d = S_CHK;
      S_CHK:     if (i_Rx_DV) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (tmo_fire) state_d = S_IDLE;
  end

  // Datapath and output next values: checksum, index, timer, strobes, status
  always_comb begin
    cmd_d        = cmd_q;
    len_d        = len_q;
    chk_d        = chk_q;
    idx_d        = idx_q;
    data_dv_d    = 1'b0;
    data_byte_d  = data_byte_q;
    data_index_d = data_index_q;
    done_d       = 1'b0;
    ok_d         = ok_q;
    err_d        = err_q;
    timer_d      = (i_Rx_DV || state_q == S_IDLE) ? 16'd0 : timer_q + 16'd1;
    busy_d       = (state_d != S_IDLE);
    if (i_Rx_DV) begin
      case (state_q)
        S_CMD: begin
          cmd_d = i_Rx_Byte;
          chk_d = i_Rx_Byte;
        end
        S_LEN: begin
          if (i_Rx_Byte > C_MAX_LEN) begin
            done_d = 1'b1;
            ok_d   = 1'b0;
            err_d  = ERR_LEN;
          end else begin
            len_d = i_Rx_Byte;
            chk_d = chk_q ^ i_Rx_Byte;
            idx_d = 8'd0;
          end
        end
        S_PAYLOAD: begin
          data_dv_d    = 1'b1;
          data_byte_d  = i_Rx_Byte;
          data_index_d = idx_q;
          chk_d        = chk_q ^ i_Rx_Byte;
          idx_d        = idx_q + 8'd1;
        end
        S_CHK: begin
          done_d = 1'b1;
          ok_d   = (i_Rx_Byte == chk_q);
          err_d  = (i_Rx_Byte == chk_q) ? ERR_NONE : ERR_CHK;
        end
        default: ;
      endcase
    end
    if (tmo_fire) begin
      done_d = 1'b1;
      ok_d   = 1'b0;
      err_d  = ERR_TMO;
    end
  end

  // Datapath and output registers
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      cmd_q        <= 8'd0;
      len_q        <= 8'd0;
      chk_q        <= 8'd0;
      idx_q        <= 8'd0;
      timer_q      <= 16'd0;
      data_dv_q    <= 1'b0;
      data_byte_q  <= 8'd0;
      data_index_q <= 8'd0;
      done_q       <= 1'b0;
      ok_q         <= 1'b0;
      err_q        <= ERR_NONE;
      busy_q       <= 1'b0;
    end else begin
      cmd_q        <= cmd_d;
      len_q        <= len_d;
      chk_q        <= chk_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      data_dv_q    <= data_dv_d;
      data_byte_q  <= data_byte_d;
      data_index_q <= data_index_d;
      done_q       <= done_d;
      ok_q         <= ok_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign o_Cmd        = cmd_q;
  assign o_Len        = len_q;
  assign o_Data_DV    = data_dv_q;
  assign o_Data_Byte  = data_byte_q;
  assign o_Data_Index = data_index_q;
  assign o_Frame_Done = done_q;
  assign o_Frame_Ok   = ok_q;
  assign o_Err_Code   = err_q;
  assign o_Busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cmd_parser
//  Purpose  : Scoreboard bench for uart_cmd_parser: frames are built at the
//             byte-list level, expected payload/status events are queued by
//             the stimulus and popped by an independent output monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_cmd_parser;

  localparam int         TMO  = 200;
  localparam int         ML   = 16;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'd0;
  logic [7:0] o_cmd, o_len, o_data_byte, o_data_index;
  logic       o_data_dv, o_done, o_ok, o_busy;
  logic [1:0] o_err;

  uart_cmd_parser #(
    .SYNC_BYTE   (SYNC),
    .MAX_LEN     (ML),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Rx_DV     (rx_dv),
    .i_Rx_Byte   (rx_byte),
    .o_Cmd       (o_cmd),
    .o_Len       (o_len),
    .o_Data_DV   (o_data_dv),
    .o_Data_Byte (o_data_byte),
    .o_Data_Index(o_data_index),
    .o_Frame_Done(o_done),
    .o_Frame_Ok  (o_ok),
    .o_Err_Code  (o_err),
    .o_Busy      (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_done;
    logic [7:0] b;
    logic [7:0] idx;
    logic [7:0] cmd;
    logic [7:0] len;
    logic       ok;
    logic [1:0] err;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_cmd = 8'd0;
  logic [7:0] last_len = 8'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_data(input logic [7:0] b, input logic [7:0] idx,
                           input logic [7:0] cmd, input logic [7:0] len);
    sb.push_back('{is_done: 1'b0, b: b, idx: idx, cmd: cmd, len: len, ok: 1'b0, err: 2'b00});
  endtask

  task automatic push_done(input logic ok, input logic [1:0] err,
                           input logic [7:0] cmd, input logic [7:0] len);
    sb.push_back('{is_done: 1'b1, b: 8'd0, idx: 8'd0, cmd: cmd, len: len, ok: ok, err: err});
  endtask

  // Called at a falling edge: one-cycle strobe, then 'gap' idle cycles
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  function automatic int pick_gap(input int gmax);
    return (gmax == 0) ? 0 : int'($urandom_range(0, gmax));
  endfunction

  // kind: 0 good checksum, 1 corrupted checksum, 2 stop after payload list and go silent
  task automatic do_frame(input logic [7:0] cmd, input logic [7:0] len,
                          input logic [7:0] pl[$], input int kind, input int gmax);
    logic [7:0] x;
    send_byte(SYNC, pick_gap(gmax));
    send_byte(cmd, pick_gap(gmax));
    last_cmd = cmd;
    if (int'(len) > ML) begin
      push_done(1'b0, 2'b10, cmd, last_len);
      send_byte(len, pick_gap(gmax));
      return;
    end
    last_len = len;
    x = cmd ^ len;
    send_byte(len, pick_gap(gmax));
    for (int i = 0; i < pl.size(); i++) begin
      push_data(pl[i], 8'(i), cmd, len);
      x = x ^ pl[i];
      send_byte(pl[i], pick_gap(gmax));
    end
    if (kind == 2) begin
      push_done(1'b0, 2'b11, cmd, len);
      repeat (TMO + 3) @(negedge clk);
    end else if (kind == 1) begin
      push_done(1'b0, 2'b01, cmd, len);
      send_byte(x ^ 8'($urandom_range(1, 255)), pick_gap(gmax));
    end else begin
      push_done(1'b1, 2'b00, cmd, len);
      send_byte(x, pick_gap(gmax));
    end
  endtask

  task automatic garbage(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == SYNC) b = 8'h5A;
      send_byte(b, int'($urandom_range(0, 2)));
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {o_cmd, o_len, o_data_dv, o_data_byte, o_data_index,
                 o_done, o_ok, o_err, o_busy}, 64'd0);
  endtask

  // Monitor: every payload strobe or frame-done pulse must match the queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_data_dv || o_done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got dv=%0b done=%0b expected no event at %0t",
                   o_data_dv, o_done, $time);
        end else begin
          e = sb.pop_front();
          check("event_kind", {o_done, o_data_dv}, {e.is_done, ~e.is_done});
          check("event_cmd", o_cmd, e.cmd);
          check("event_len", o_len, e.len);
          if (e.is_done) begin
            check("done_ok", o_ok, e.ok);
            check("done_err", o_err, e.err);
            check("done_busy", o_busy, 1'b0);
          end else begin
            check("data_byte", o_data_byte, e.b);
            check("data_index", o_data_index, e.idx);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of run expected finish within bound");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] len;
    int         kind;

    repeat (3) @(negedge clk);
    check_all_zero("reset_in_reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_after_release");

    // Basic good frame, zero-length frame, bad checksum
    q = {8'h11, 8'h22};
    do_frame(8'h10, 8'h02, q, 0, 0);
    @(negedge clk);
    check("hold_cmd", o_cmd, 8'h10);
    check("hold_len", o_len, 8'h02);
    q = {};
    do_frame(8'h20, 8'h00, q, 0, 1);
    q = {8'h11, 8'h22};
    do_frame(8'h10, 8'h02, q, 1, 0);

    // Oversized length, then recovery; exactly MAX_LEN is legal
    q = {};
    do_frame(8'h10, 8'h11, q, 0, 0);
    @(negedge clk);
    check("len_err_busy", o_busy, 1'b0);
    q = {8'h11, 8'h22};
    do_frame(8'h10, 8'h02, q, 0, 0);
    q = {};
    for (int i = 0; i < ML; i++) q.push_back(8'($urandom));
    do_frame(8'h33, 8'(ML), q, 0, 0);

    // Timeout after CMD
    send_byte(SYNC, 0);
    push_done(1'b0, 2'b11, 8'h10, last_len);
    last_cmd = 8'h10;
    send_byte(8'h10, TMO + 3);

    // Strobe in the expiry cycle wins: T-1 idle cycles between strobes
    send_byte(SYNC, 0);
    send_byte(8'h10, TMO - 1);
    send_byte(8'h00, 0);
    push_done(1'b1, 2'b00, 8'h10, 8'h00);
    last_cmd = 8'h10;
    last_len = 8'h00;
    send_byte(8'h10, 2);

    // T idle cycles expire; the following bytes land in idle and are dropped
    send_byte(SYNC, 0);
    push_done(1'b0, 2'b11, 8'h10, last_len);
    send_byte(8'h10, TMO);
    send_byte(8'h00, 0);
    send_byte(8'h10, 3);

    // Garbage before a frame
    send_byte(8'h00, 0);
    send_byte(8'hFF, 1);
    send_byte(8'h3C, 0);
    q = {8'h11, 8'h22};
    do_frame(8'h10, 8'h02, q, 0, 0);

    // Reset mid-payload drops the frame silently
    send_byte(SYNC, 0);
    send_byte(8'h10, 0);
    send_byte(8'h02, 0);
    push_data(8'h11, 8'd0, 8'h10, 8'h02);
    send_byte(8'h11, 0);
    check("busy_mid_frame", o_busy, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset_mid_payload");
    last_cmd = 8'd0;
    last_len = 8'd0;
    repeat (3) @(negedge clk);
    check("no_done_after_reset", o_done, 1'b0);
    q = {8'h11, 8'h22};
    do_frame(8'h10, 8'h02, q, 0, 0);

    // Randomized frames with garbage and mixed spacing
    for (int f = 0; f < 60; f++) begin
      garbage(int'($urandom_range(0, 2)));
      kind = int'($urandom_range(0, 9));
      len  = ($urandom_range(0, 3) == 0) ? 8'(ML) : 8'($urandom_range(0, ML));
      if (kind == 9) len = 8'($urandom_range(ML + 1, 255));
      q = {};
      if (kind == 8) begin
        for (int i = 0; i < int'($urandom_range(0, int'(len))); i++) q.push_back(8'($urandom));
        do_frame(8'($urandom), len, q, 2, 3);
      end else begin
        if (kind != 9) for (int i = 0; i < int'(len); i++) q.push_back(8'($urandom));
        do_frame(8'($urandom), len, q, (kind >= 6) ? 1 : 0, ($urandom_range(0, 1) == 1) ? 3 : 0);
      end
    end

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
